i2c_reg_sequencer: RTL and testbench

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

---
 rtl/i2c_reg_sequencer.sv | 129 ++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns single register read/write commands into i2c_master byte phases
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [7:0] address,
  output logic       transfer_start,
  output logic       transfer_continues,
  output logic [7:0] data_tx,
  input  logic       transfer_ready,
  input  logic       interrupt,
  input  logic       transaction_complete,
  input  logic       nack,
  input  logic       start_err,
  input  logic       arbitration_err,
  input  logic [7:0] data_rx
);
  typedef enum logic [2:0] {IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, WAIT_IDLE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd;
  logic [6:0]    dev;
  logic [7:0]    reg_a;
  logic [7:0]    wd;
  logic [1:0]    err;
  logic          bus_fault;
  assign cmd_ready = (state == IDLE) && transfer_ready && !reset;
  assign bus_fault = !transaction_complete || start_err || arbitration_err;
  // sequencer: one byte phase per state, interrupt beats timeout, error codes held until WAIT_IDLE reports them
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      rd                 <= 1'b0;
      dev                <= '0;
      reg_a              <= '0;
      wd                 <= '0;
      err                <= '0;
      rsp_valid          <= 1'b0;
      rsp_err            <= '0;
      rsp_rdata          <= '0;
      address            <= '0;
      data_tx            <= '0;
      transfer_start     <= 1'b0;
      transfer_continues <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= cnt + 1'b1;
      if (state == IDLE) begin
        cnt <= '0;
        if (cmd_valid && transfer_ready) begin
          rd                 <= cmd_read;
          dev                <= cmd_dev_addr;
          reg_a              <= cmd_reg_addr;
          wd                 <= cmd_wdata;
          err                <= '0;
          address            <= {cmd_dev_addr, 1'b0};
          transfer_start     <= 1'b1;
          transfer_continues <= 1'b1;
          state              <= ADDR_W;
        end
      end else if (state == WAIT_IDLE) begin
        cnt <= '0;
        if (transfer_ready) begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err != 2'd0) ? 8'h00 : rsp_rdata;
          state     <= IDLE;
        end
      end else if (interrupt) begin
        cnt <= '0;
        if (bus_fault) begin
          err                <= 2'd2;
          transfer_start     <= 1'b0;
          transfer_continues <= 1'b0;
          state              <= WAIT_IDLE;
        end else if (nack && state != RDATA) begin
          err                <= 2'd1;
          transfer_start     <= 1'b0;
          transfer_continues <= 1'b0;
          state              <= WAIT_IDLE;
        end else begin
          case (state)
            ADDR_W: begin
              transfer_start     <= 1'b0;
              transfer_continues <= 1'b1;
              data_tx            <= reg_a;
              state              <= REG;
            end
            REG: begin
              transfer_start     <= rd;
              transfer_continues <= 1'b0;
              address            <= rd ? {dev, 1'b1} : address;
              data_tx            <= rd ? data_tx : wd;
              state              <= rd ? ADDR_R : WDATA;
            end
            ADDR_R: begin
              transfer_start     <= 1'b0;
              transfer_continues <= 1'b0;
              state              <= RDATA;
            end
            WDATA: state <= WAIT_IDLE;
            default: begin
              rsp_rdata <= data_rx;
              state     <= WAIT_IDLE;
            end
          endcase
        end
      end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        cnt                <= '0;
        err                <= 2'd3;
        transfer_start     <= 1'b0;
        transfer_continues <= 1'b0;
        state              <= WAIT_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed transactions checked each cycle against a phase-list model
module tb_i2c_reg_sequencer;
  localparam int TO = 100;
  localparam int AW = 0, RG = 1, WD = 2, AR = 3, RD = 4;
  logic       clk_in = 0, reset = 1, cmd_valid = 0, cmd_read = 0;
  logic [6:0] cmd_dev_addr = 0;
  logic [7:0] cmd_reg_addr = 0, cmd_wdata = 0, data_rx = 0;
  logic       transfer_ready = 0, interrupt = 0, transaction_complete = 0, nack = 0;
  logic       start_err = 0, arbitration_err = 0;
  logic       cmd_ready, rsp_valid, transfer_start, transfer_continues;
  logic [7:0] rsp_rdata, address, data_tx;
  logic [1:0] rsp_err;
  int tot = 0, bad = 0;
  bit run = 0;
  bit busy = 0, waiting = 0, m_rd = 0;
  int idx = 0, nph = 0, age = 0;
  int kind[4];
  logic [6:0] m_dev = 0;
  logic [7:0] m_reg = 0, m_wd = 0;
  logic [1:0] m_err = 0;
  logic       e_valid = 0, e_ts = 0, e_tc = 0;
  logic [1:0] e_err = 0;
  logic [7:0] e_rdata = 0, e_addr = 0, e_dtx = 0;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read(cmd_read), .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .data_tx(data_tx), .transfer_ready(transfer_ready), .interrupt(interrupt),
    .transaction_complete(transaction_complete), .nack(nack), .start_err(start_err),
    .arbitration_err(arbitration_err), .data_rx(data_rx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task enter(int i);
    idx = i;
    age = 0;
    case (kind[i])
      AW: begin e_addr = {m_dev, 1'b0}; e_ts = 1; e_tc = 1; end
      RG: begin e_ts = 0; e_tc = 1; e_dtx = m_reg; end
      WD: begin e_dtx = m_wd; e_tc = 0; end
      AR: begin e_ts = 1; e_addr = {m_dev, 1'b1}; e_tc = 0; end
      default: begin e_ts = 0; e_tc = 0; end
    endcase
  endtask

  task abort(logic [1:0] e);
    m_err = e;
    e_ts = 0;
    e_tc = 0;
    waiting = 1;
  endtask

  always @(posedge clk_in) begin
    e_valid = 0;
    if (reset) begin
      busy = 0; waiting = 0;
      e_err = 0; e_rdata = 0; e_addr = 0; e_dtx = 0; e_ts = 0; e_tc = 0;
    end else if (!busy) begin
      if (cmd_valid && transfer_ready) begin
        m_rd = cmd_read; m_dev = cmd_dev_addr; m_reg = cmd_reg_addr; m_wd = cmd_wdata;
        nph = cmd_read ? 4 : 3;
        kind[0] = AW; kind[1] = RG; kind[2] = cmd_read ? AR : WD; kind[3] = RD;
        busy = 1; waiting = 0;
        enter(0);
      end
    end else if (waiting) begin
      if (transfer_ready) begin
        e_valid = 1;
        e_err = m_err;
        if (m_err != 0) e_rdata = 0;
        busy = 0; waiting = 0;
      end
    end else begin
      age++;
      if (interrupt) begin
        if (!transaction_complete) abort(2);
        else if (nack && kind[idx] != RD) abort(1);
        else if (idx == nph - 1) begin
          if (kind[idx] == RD) e_rdata = data_rx;
          m_err = 0;
          waiting = 1;
        end else enter(idx + 1);
      end else if (age == TO) abort(3);
    end
  end

  always @(negedge clk_in) if (run) begin
    chk("cmd_ready", cmd_ready, !busy && transfer_ready && !reset);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("address", address, e_addr);
    chk("data_tx", data_tx, e_dtx);
    chk("transfer_start", transfer_start, e_ts);
    chk("transfer_continues", transfer_continues, e_tc);
  end

  task cyc(int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task issue(bit r, logic [6:0] dv, logic [7:0] rg, logic [7:0] wdv);
    cmd_read = r; cmd_dev_addr = dv; cmd_reg_addr = rg; cmd_wdata = wdv;
    cmd_valid = 1;
    cyc(1);
    cmd_valid = 0;
    transfer_ready = 0;
  endtask

  task irq(int gap, bit tc, bit nk, logic [7:0] rx, bit ae);
    if (gap > 0) cyc(gap);
    interrupt = 1; transaction_complete = tc; nack = nk; data_rx = rx; arbitration_err = ae;
    cyc(1);
    interrupt = 0; transaction_complete = 0; nack = 0; data_rx = 0; arbitration_err = 0;
  endtask

  task wait_rsp(string nm, logic [1:0] er, logic [7:0] rdv);
    transfer_ready = 1;
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) cyc(1);
    chk({nm, " valid"}, rsp_valid, 1);
    chk({nm, " err"}, rsp_err, er);
    chk({nm, " rdata"}, rsp_rdata, rdv);
    cyc(1);
  endtask

  task wr_ok(logic [6:0] dv, logic [7:0] rg, logic [7:0] wdv);
    issue(0, dv, rg, wdv);
    irq(2, 1, 0, 0, 0);
    irq(2, 1, 0, 0, 0);
    irq(2, 1, 0, 0, 0);
    wait_rsp("wr_ok", 0, rsp_rdata);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1);
    run = 1;
    cyc(2);
    chk("rst address", address, 0);
    chk("rst data_tx", data_tx, 0);
    chk("rst start", transfer_start, 0);
    chk("rst cont", transfer_continues, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rdata", rsp_rdata, 0);
    reset = 0;
    transfer_ready = 1;
    cyc(1);
    chk("idle ready", cmd_ready, 1);
    issue(0, 7'h2A, 8'h10, 8'h5A);
    chk("w address", address, 8'h54);
    chk("w start", transfer_start, 1);
    chk("w cont", transfer_continues, 1);
    irq(2, 1, 0, 0, 0);
    chk("w reg dtx", data_tx, 8'h10);
    chk("w reg start", transfer_start, 0);
    chk("w reg cont", transfer_continues, 1);
    irq(2, 1, 0, 0, 0);
    chk("w data dtx", data_tx, 8'h5A);
    chk("w data cont", transfer_continues, 0);
    irq(2, 1, 0, 0, 0);
    cyc(3);
    chk("w hold rsp", rsp_valid, 0);
    wait_rsp("write", 0, 0);
    issue(1, 7'h50, 8'h03, 8'h00);
    chk("r address", address, 8'hA0);
    transfer_ready = 1;
    cmd_valid = 1; cmd_dev_addr = 7'h11;
    cyc(2);
    cmd_valid = 0;
    transfer_ready = 0;
    chk("r ignore cmd", address, 8'hA0);
    irq(2, 1, 0, 0, 0);
    chk("r reg dtx", data_tx, 8'h03);
    irq(2, 1, 0, 0, 0);
    chk("r rs address", address, 8'hA1);
    chk("r rs start", transfer_start, 1);
    chk("r rs cont", transfer_continues, 0);
    irq(2, 1, 0, 0, 0);
    chk("r data start", transfer_start, 0);
    irq(2, 1, 1, 8'hC3, 0);
    wait_rsp("read", 0, 8'hC3);
    issue(1, 7'h50, 8'h07, 8'h00);
    irq(1, 1, 0, 0, 0);
    irq(1, 0, 0, 8'h77, 1);
    chk("arb start", transfer_start, 0);
    chk("arb cont", transfer_continues, 0);
    wait_rsp("arb", 2, 0);
    issue(0, 7'h2A, 8'h10, 8'h5A);
    irq(2, 1, 1, 0, 0);
    chk("nack start", transfer_start, 0);
    chk("nack cont", transfer_continues, 0);
    cyc(3);
    chk("nack hold rsp", rsp_valid, 0);
    wait_rsp("nack", 1, 0);
    wr_ok(7'h11, 8'h22, 8'h33);
    issue(0, 7'h2A, 8'h10, 8'h5A);
    cyc(TO - 1);
    chk("to pre start", transfer_start, 1);
    cyc(1);
    chk("to start", transfer_start, 0);
    chk("to cont", transfer_continues, 0);
    wait_rsp("timeout", 3, 0);
    issue(0, 7'h2A, 8'h10, 8'h5A);
    irq(TO - 1, 1, 0, 0, 0);
    chk("to edge dtx", data_tx, 8'h10);
    chk("to edge cont", transfer_continues, 1);
    irq(2, 1, 0, 0, 0);
    irq(2, 1, 0, 0, 0);
    wait_rsp("to edge", 0, 0);
    issue(0, 7'h2A, 8'h10, 8'h5A);
    irq(2, 1, 0, 0, 0);
    irq(2, 1, 0, 0, 0);
    chk("mid wdata dtx", data_tx, 8'h5A);
    reset = 1;
    transfer_ready = 1;
    cyc(1);
    chk("mid rst address", address, 0);
    chk("mid rst data_tx", data_tx, 0);
    chk("mid rst start", transfer_start, 0);
    chk("mid rst cont", transfer_continues, 0);
    reset = 0;
    cyc(5);
    chk("mid rst no rsp", rsp_valid, 0);
    wr_ok(7'h2A, 8'h44, 8'h99);
    chk("post rst err", rsp_err, 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
